// File: rtl/cm3_sys_ctrl_pkg.sv
// Shared types and constants for the cm3 system/reset controller.
package cm3_sys_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_e;

  // Register word offsets (PADDR[3:2])
  localparam logic [1:0] OFF_CAUSE = 2'd0;
  localparam logic [1:0] OFF_SWRST = 2'd1;
  localparam logic [1:0] OFF_HOLD  = 2'd2;
  localparam logic [1:0] OFF_LKEN  = 2'd3;

  localparam logic [7:0] SWRST_KEY = 8'h5A;

  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned CAUSE_POR  = 0;
  localparam int unsigned CAUSE_SYS  = 1;
  localparam int unsigned CAUSE_LOCK = 2;
  localparam int unsigned CAUSE_SW   = 3;

  // Stagger counter width: clog2(STAGGER+1), never below 1.
  function automatic int unsigned stg_width(input int unsigned stagger);
    return (stagger == 0) ? 1 : $clog2(stagger + 1);
  endfunction

endpackage

// File: rtl/cm3_rst_seq.sv
// Reset sequencer: hold counter, staggered per-domain release and RST_N registers.
module cm3_rst_seq
  import cm3_sys_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned CTR_W    = 8,
  parameter int unsigned HOLD_CYC = 15,
  parameter int unsigned STAGGER  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_i,
  input  logic [NUM_DOM-1:0] mask_i,
  input  logic [CTR_W-1:0]   hold_i,
  output logic               run_o,
  output logic [NUM_DOM-1:0] rst_n_o
);

  localparam int unsigned STG_W = stg_width(STAGGER);

  seq_state_e         state_q;
  logic [CTR_W-1:0]   cnt_q;
  logic [STG_W-1:0]   stg_q;
  logic [NUM_DOM-1:0] mask_q;
  logic [NUM_DOM-1:0] rst_q;
  logic [NUM_DOM-1:0] rel_c;

  // Domains released in the next slot: lowest pending one, or all when unstaggered.
  assign rel_c = (STAGGER == 0) ? mask_q : (mask_q & (~mask_q + NUM_DOM'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= CTR_W'(HOLD_CYC);
      stg_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (trig_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= hold_i;
            mask_q  <= mask_i;
            rst_q   <= rst_q & ~mask_i;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_RELEASE;
            stg_q   <= STG_W'(STAGGER);
            mask_q  <= mask_q & ~rel_c;
            rst_q   <= rst_q | rel_c;
          end else begin
            cnt_q <= cnt_q - CTR_W'(1);
          end
        end
        ST_RELEASE: begin
          if (mask_q == '0) begin
            state_q <= ST_RUN;
          end else if (stg_q == '0) begin
            stg_q  <= STG_W'(STAGGER);
            mask_q <= mask_q & ~rel_c;
            rst_q  <= rst_q | rel_c;
          end else begin
            stg_q <= stg_q - STG_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign run_o   = (state_q == ST_RUN);
  assign rst_n_o = rst_q;

endmodule

// File: rtl/cm3_sys_ctrl.sv
// cm3 system/reset controller: APB4 register file, reset triggers and cause logging.
// Optional lockup-triggered reset enabled by defining CM3_SYS_CTRL_LOCKUP_RST_EN.
module cm3_sys_ctrl
  import cm3_sys_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOM    = 4,
  parameter int unsigned CTR_W      = 8,
  parameter int unsigned HOLD_CYC   = 15,
  parameter int unsigned STAGGER    = 2,
  parameter int unsigned PADDR_SIZE = 4
) (
  input  logic                  CLK,
  input  logic                  PORESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  SYSRESETREQ,
  input  logic                  LOCKUP,
  output logic [NUM_DOM-1:0]    RST_N
);

  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CTR_W-1:0]   hold_q, hold_d;
  logic               lken_c;
  logic               lock_c;
  logic [1:0]         word_c;
  logic               wr_c, sw_hit_c, key_ok_c, sw_go_c, run_c, trig_c;
  logic [NUM_DOM-1:0] mask_c;
  logic [31:0]        strb_bits_c;
  logic               unused_c;

  assign word_c      = PADDR[3:2];
  assign wr_c        = PSEL & PENABLE & PWRITE;
  assign strb_bits_c = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign unused_c    = ^{PADDR, PWDATA, PSTRB, LOCKUP};

  // Software reset is accepted only with the key, top-lane strobe, a nonzero mask and in RUN.
  assign sw_hit_c = wr_c && (word_c == OFF_SWRST);
  assign key_ok_c = (PWDATA[31:24] == SWRST_KEY) && PSTRB[3] && (|PWDATA[NUM_DOM-1:0]);
  assign sw_go_c  = sw_hit_c && key_ok_c && run_c;
  assign PSLVERR  = sw_hit_c && !(key_ok_c && run_c);
  assign PREADY   = 1'b1;

`ifdef CM3_SYS_CTRL_LOCKUP_RST_EN
  logic lken_q;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn)                                    lken_q <= 1'b0;
    else if (wr_c && (word_c == OFF_LKEN) && PSTRB[0]) lken_q <= PWDATA[0];
  end

  assign lken_c = lken_q;
  assign lock_c = LOCKUP & lken_q;
`else
  assign lken_c = 1'b0;
  assign lock_c = 1'b0;
`endif

  assign trig_c = run_c & (SYSRESETREQ | lock_c | sw_go_c);
  assign mask_c = {NUM_DOM{SYSRESETREQ | lock_c}} | (sw_go_c ? PWDATA[NUM_DOM-1:0] : '0);

  // Cause bits: set wins over a same-cycle write-1-to-clear.
  always_comb begin
    cause_d = cause_q;
    if (wr_c && (word_c == OFF_CAUSE) && PSTRB[0]) cause_d = cause_q & ~PWDATA[CAUSE_W-1:0];
    if (SYSRESETREQ) cause_d[CAUSE_SYS]  = 1'b1;
    if (lock_c)      cause_d[CAUSE_LOCK] = 1'b1;
    if (sw_go_c)     cause_d[CAUSE_SW]   = 1'b1;
  end

  always_comb begin
    hold_d = hold_q;
    if (wr_c && (word_c == OFF_HOLD))
      hold_d = (hold_q & ~strb_bits_c[CTR_W-1:0]) | (PWDATA[CTR_W-1:0] & strb_bits_c[CTR_W-1:0]);
  end

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      cause_q <= CAUSE_W'(1) << CAUSE_POR;
      hold_q  <= CTR_W'(HOLD_CYC);
    end else begin
      cause_q <= cause_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (word_c)
        OFF_CAUSE: PRDATA = 32'(cause_q);
        OFF_HOLD:  PRDATA = 32'(hold_q);
        OFF_LKEN:  PRDATA = 32'(lken_c);
        default:   PRDATA = '0;
      endcase
    end
  end

  cm3_rst_seq #(
    .NUM_DOM  (NUM_DOM),
    .CTR_W    (CTR_W),
    .HOLD_CYC (HOLD_CYC),
    .STAGGER  (STAGGER)
  ) u_seq (
    .clk     (CLK),
    .rst_n   (PORESETn),
    .trig_i  (trig_c),
    .mask_i  (mask_c),
    .hold_i  (hold_q),
    .run_o   (run_c),
    .rst_n_o (RST_N)
  );

endmodule

// File: tb/tb_cm3_sys_ctrl.sv
// Self-checking bench for cm3_sys_ctrl (default parameters).
`timescale 1ns/1ps
module tb_cm3_sys_ctrl;

  localparam int STEP = 3;  // STAGGER + 1
`ifdef CM3_SYS_CTRL_LOCKUP_RST_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  localparam logic [3:0] A_CAUSE = 4'h0, A_SWRST = 4'h4, A_HOLD = 4'h8, A_LKEN = 4'hC;

  logic        CLK = 1'b0;
  logic        PORESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        SYSRESETREQ = 1'b0, LOCKUP = 1'b0;
  logic [3:0]  RST_N;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[17];

  cm3_sys_ctrl #(
    .NUM_DOM(4), .CTR_W(8), .HOLD_CYC(15), .STAGGER(2), .PADDR_SIZE(4)
  ) dut (
    .CLK(CLK), .PORESETn(PORESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP), .RST_N(RST_N)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Both APB tasks start and end on a falling edge with the bus idle.
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic sysreq, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge CLK);
    PENABLE = 1'b1;
    if (sysreq) SYSRESETREQ = 1'b1;
    #1 err = PSLVERR;
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (sysreq) SYSRESETREQ = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1 data = PRDATA; err = PSLVERR;
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(name, d, exp);
  endtask

  task automatic wr_check(input string name, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_err);
    logic e;
    apb_write(addr, data, strb, 1'b0, e);
    check(name, 32'(e), 32'(exp_err));
  endtask

  // k counts rising edges since the trigger edge; samples from k0 up to first RUN cycle.
  task automatic run_seq(input logic [3:0] mask, input int hold, input int k0, input string name);
    int         last, rank;
    logic [3:0] exp;
    last = hold + 1 + STEP * ($countones(mask) - 1);
    for (int k = k0; k <= last + 1; k++) begin
      if (k != k0) @(negedge CLK);
      rank = 0;
      for (int i = 0; i < 4; i++) begin
        if (!mask[i]) exp[i] = 1'b1;
        else begin
          exp[i] = (k >= hold + 1 + STEP * rank);
          rank++;
        end
      end
      check($sformatf("%s k=%0d", name, k), 32'(RST_N), 32'(exp));
    end
  endtask

  initial begin
    logic e;

    tbl[0]  = mk(1'b0, A_CAUSE, 32'h0,        4'hF, 32'h1, 1'b0);
    tbl[1]  = mk(1'b1, A_HOLD,  32'h3,        4'hF, 32'h0, 1'b0);
    tbl[2]  = mk(1'b0, A_HOLD,  32'h0,        4'hF, 32'h3, 1'b0);
    tbl[3]  = mk(1'b1, A_HOLD,  32'h0000AA00, 4'h2, 32'h0, 1'b0);
    tbl[4]  = mk(1'b0, A_HOLD,  32'h0,        4'hF, 32'h3, 1'b0);
    tbl[5]  = mk(1'b1, A_HOLD,  32'h77,       4'h0, 32'h0, 1'b0);
    tbl[6]  = mk(1'b0, A_HOLD,  32'h0,        4'hF, 32'h3, 1'b0);
    tbl[7]  = mk(1'b1, A_SWRST, 32'h11000001, 4'hF, 32'h0, 1'b1);
    tbl[8]  = mk(1'b1, A_SWRST, 32'h5A000000, 4'hF, 32'h0, 1'b1);
    tbl[9]  = mk(1'b1, A_SWRST, 32'h5A000001, 4'h7, 32'h0, 1'b1);
    tbl[10] = mk(1'b0, A_SWRST, 32'h0,        4'hF, 32'h0, 1'b0);
    tbl[11] = mk(1'b1, A_CAUSE, 32'h1,        4'h2, 32'h0, 1'b0);
    tbl[12] = mk(1'b0, A_CAUSE, 32'h0,        4'hF, 32'h1, 1'b0);
    tbl[13] = mk(1'b1, A_LKEN,  32'h1,        4'hF, 32'h0, 1'b0);
    tbl[14] = mk(1'b0, A_LKEN,  32'h0,        4'hF, 32'(LK), 1'b0);
    tbl[15] = mk(1'b1, A_LKEN,  32'h0,        4'hF, 32'h0, 1'b0);
    tbl[16] = mk(1'b0, A_LKEN,  32'h0,        4'hF, 32'h0, 1'b0);

    // Power-on reset
    repeat (3) @(negedge CLK);
    check("por rst_n", 32'(RST_N), 32'h0);
    check("por prdata", PRDATA, 32'h0);
    check("por pslverr", 32'(PSLVERR), 32'h0);
    check("pready", 32'(PREADY), 32'h1);
    PORESETn = 1'b1;
    run_seq(4'hF, 15, 0, "por seq");

    // Register table in RUN
    for (int i = 0; i < 17; i++) begin
      logic [31:0] d;
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, e);
      end else begin
        apb_read(tbl[i].addr, d, e);
        check($sformatf("tbl[%0d] rdata", i), d, tbl[i].exp_rd);
      end
      check($sformatf("tbl[%0d] pslverr", i), 32'(e), 32'(tbl[i].exp_err));
    end
    check("rejected swrst rst_n", 32'(RST_N), 32'hF);

    // Software reset of domains 1 and 2 with HOLD=3
    wr_check("swrst 0x6 err", A_SWRST, 32'h5A000006, 4'hF, 1'b0);
    run_seq(4'b0110, 3, 0, "swrst seq");
    rd_check("cause after sw", A_CAUSE, 32'h9);

    // SYSRESETREQ in the same cycle as a software reset of domain 1
    apb_write(A_SWRST, 32'h5A000002, 4'hF, 1'b1, e);
    check("simul err", 32'(e), 32'h0);
    run_seq(4'hF, 3, 0, "simul seq");
    rd_check("cause simul", A_CAUSE, 32'hB);
    wr_check("cause w1c 9", A_CAUSE, 32'h9, 4'h1, 1'b0);
    rd_check("cause after w1c 9", A_CAUSE, 32'h2);
    wr_check("cause w1c 2", A_CAUSE, 32'h2, 4'h1, 1'b0);
    rd_check("cause cleared", A_CAUSE, 32'h0);

    // Software reset rejected while in HOLD; sequence length unchanged
    wr_check("hold=8", A_HOLD, 32'h8, 4'hF, 1'b0);
    wr_check("swrst d0 err", A_SWRST, 32'h5A000001, 4'hF, 1'b0);
    check("swrst d0 low", 32'(RST_N), 32'hE);
    wr_check("swrst in hold err", A_SWRST, 32'h5A000008, 4'hF, 1'b1);
    run_seq(4'b0001, 8, 2, "mid seq");

    // PORESETn during RELEASE
    wr_check("hold=1", A_HOLD, 32'h1, 4'hF, 1'b0);
    wr_check("swrst all err", A_SWRST, 32'h5A00000F, 4'hF, 1'b0);
    repeat (6) @(negedge CLK);
    check("release partial", 32'(RST_N), 32'h3);
    #2 PORESETn = 1'b0;
    #1 check("async por rst_n", 32'(RST_N), 32'h0);
    check("async por prdata", PRDATA, 32'h0);
    @(negedge CLK);
    PORESETn = 1'b1;
    run_seq(4'hF, 15, 0, "re-por seq");
    rd_check("cause re-por", A_CAUSE, 32'h1);
    rd_check("hold re-por", A_HOLD, 32'hF);

    // SYSRESETREQ held high with HOLD=0 retriggers after return to RUN
    wr_check("hold=0", A_HOLD, 32'h0, 4'hF, 1'b0);
    SYSRESETREQ = 1'b1;
    @(negedge CLK);
    run_seq(4'hF, 0, 0, "sysreq seq1");
    @(negedge CLK);
    SYSRESETREQ = 1'b0;
    run_seq(4'hF, 0, 0, "sysreq seq2");
    rd_check("cause sysreq", A_CAUSE, 32'h3);

    // LOCKUP with LKEN=0 never resets
    LOCKUP = 1'b1;
    @(negedge CLK);
    LOCKUP = 1'b0;
    check("lockup lken0 k0", 32'(RST_N), 32'hF);
    @(negedge CLK);
    check("lockup lken0 k1", 32'(RST_N), 32'hF);
    rd_check("cause lken0", A_CAUSE, 32'h3);

    // LOCKUP with LKEN written to 1
    wr_check("lken=1", A_LKEN, 32'h1, 4'hF, 1'b0);
    rd_check("lken read", A_LKEN, 32'(LK));
    LOCKUP = 1'b1;
    @(negedge CLK);
    LOCKUP = 1'b0;
`ifdef CM3_SYS_CTRL_LOCKUP_RST_EN
    run_seq(4'hF, 0, 0, "lockup seq");
    rd_check("cause lockup", A_CAUSE, 32'h7);
`else
    check("lockup off k0", 32'(RST_N), 32'hF);
    @(negedge CLK);
    check("lockup off k1", 32'(RST_N), 32'hF);
    rd_check("cause lockup off", A_CAUSE, 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
